// File: rtl/reg_write_arbiter.sv
// Register-file write arbiter: WB priority plus buffered long-latency results.
// Optional starvation guard enabled by defining RWA_STARVE_GUARD_EN.
module reg_write_arbiter #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int DEPTH    = 4,
   parameter int MAX_WAIT = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wb_we,
   input  logic [ADDR_W-1:0]          wb_reg,
   input  logic [DATA_W-1:0]          wb_data,
   input  logic                       mc_valid,
   input  logic [ADDR_W-1:0]          mc_reg,
   input  logic [DATA_W-1:0]          mc_data,
   output logic                       mc_ready,
   output logic                       RegWrite,
   output logic [ADDR_W-1:0]          WriteReg,
   output logic [DATA_W-1:0]          WriteData,
   output logic [2**ADDR_W-1:0]       pend_mask,
`ifdef RWA_STARVE_GUARD_EN
   output logic                       wb_stall,
`endif
   output logic [$clog2(DEPTH):0]     fifo_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   if (DEPTH < 2 || (2 ** PW) != DEPTH || MAX_WAIT < 1) begin : g_bad_cfg
      $error("reg_write_arbiter: bad DEPTH/MAX_WAIT");
   end

   logic [ADDR_W-1:0] reg_q [DEPTH];
   logic [DATA_W-1:0] dat_q [DEPTH];
   logic [DEPTH-1:0]  vld_q, vld_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;

   logic              we_q, we_d;
   logic [ADDR_W-1:0] wreg_q, wreg_d;
   logic [DATA_W-1:0] wdat_q, wdat_d;

   logic wb_req;
   logic fifo_empty;
   logic accept;
   logic push;
   logic pop;

   assign fifo_empty = (count_q == '0);
   assign mc_ready   = rst && (count_q < CW'(DEPTH));
   assign accept     = mc_valid && mc_ready;
   // Handshakes to r0 complete but never occupy a slot
   assign push       = accept && (mc_reg != '0);
   assign pop        = !wb_req && !fifo_empty;

`ifdef RWA_STARVE_GUARD_EN
   localparam int WW = $clog2(MAX_WAIT + 1);

   logic          stall_q, stall_d;
   logic [WW-1:0] wait_q, wait_d;

   assign wb_stall = stall_q;
   assign wb_req   = wb_we && (wb_reg != '0) && !stall_q;

   always_comb begin
      stall_d = 1'b0;
      wait_d  = wait_q;
      if (pop || fifo_empty) begin
         wait_d = '0;
      end else if (wb_req) begin
         if (wait_q == WW'(MAX_WAIT - 1)) begin
            wait_d  = '0;
            stall_d = 1'b1;
         end else begin
            wait_d = wait_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_q <= 1'b0;
         wait_q  <= '0;
      end else begin
         stall_q <= stall_d;
         wait_q  <= wait_d;
      end
   end
`else
   assign wb_req = wb_we && (wb_reg != '0);
`endif

   always_comb begin
      vld_d    = vld_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CW'(push) - CW'(pop);
      if (pop) begin
         vld_d[rd_ptr_q] = 1'b0;
         rd_ptr_d        = rd_ptr_q + 1'b1;
      end
      if (push) begin
         vld_d[wr_ptr_q] = 1'b1;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
   end

   always_comb begin
      we_d   = 1'b0;
      wreg_d = '0;
      wdat_d = '0;
      if (wb_req) begin
         we_d   = 1'b1;
         wreg_d = wb_reg;
         wdat_d = wb_data;
      end else if (pop) begin
         we_d   = 1'b1;
         wreg_d = reg_q[rd_ptr_q];
         wdat_d = dat_q[rd_ptr_q];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         we_q     <= 1'b0;
         wreg_q   <= '0;
         wdat_q   <= '0;
      end else begin
         vld_q    <= vld_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         we_q     <= we_d;
         wreg_q   <= wreg_d;
         wdat_q   <= wdat_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            reg_q[i] <= '0;
            dat_q[i] <= '0;
         end
      end else if (push) begin
         reg_q[wr_ptr_q] <= mc_reg;
         dat_q[wr_ptr_q] <= mc_data;
      end
   end

   // Slot valid bits make the mask independent of pointer arithmetic
   always_comb begin
      pend_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (vld_q[i]) pend_mask[reg_q[i]] = 1'b1;
      end
   end

   assign RegWrite   = we_q;
   assign WriteReg   = wreg_q;
   assign WriteData  = wdat_q;
   assign fifo_count = count_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter; define RWA_STARVE_GUARD_EN
// for both files to exercise the starvation guard.
module tb_reg_write_arbiter;

   logic        clk;
   logic        rst;
   logic        wb_we;
   logic [4:0]  wb_reg;
   logic [31:0] wb_data;
   logic        mc_valid;
   logic [4:0]  mc_reg;
   logic [31:0] mc_data;
   logic        mc_ready;
   logic        RegWrite;
   logic [4:0]  WriteReg;
   logic [31:0] WriteData;
   logic [31:0] pend_mask;
   logic [2:0]  fifo_count;
`ifdef RWA_STARVE_GUARD_EN
   logic        wb_stall;
`endif

   int checks;
   int errors;

   reg_write_arbiter #(
      .DATA_W(32), .ADDR_W(5), .DEPTH(4), .MAX_WAIT(8)
   ) dut (
      .clk(clk), .rst(rst),
      .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data),
      .mc_valid(mc_valid), .mc_reg(mc_reg), .mc_data(mc_data),
      .mc_ready(mc_ready),
      .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
      .pend_mask(pend_mask),
`ifdef RWA_STARVE_GUARD_EN
      .wb_stall(wb_stall),
`endif
      .fifo_count(fifo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wb_we = 0; wb_reg = 0; wb_data = 0;
      mc_valid = 0; mc_reg = 0; mc_data = 0;
   endtask

   task automatic test_reset();
      rst = 0;
      idle();
      tick();
      checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL rst_we got %0h want 0", RegWrite); end
      checks++; if (WriteReg !== 5'd0) begin errors++; $display("FAIL rst_reg got %0h want 0", WriteReg); end
      checks++; if (WriteData !== 32'd0) begin errors++; $display("FAIL rst_data got %0h want 0", WriteData); end
      checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d want 0", fifo_count); end
      checks++; if (pend_mask !== 32'd0) begin errors++; $display("FAIL rst_mask got %0h want 0", pend_mask); end
      checks++; if (mc_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %0h want 0", mc_ready); end
      rst = 1;
      tick();
      checks++; if (mc_ready !== 1'b1) begin errors++; $display("FAIL rel_ready got %0h want 1", mc_ready); end
   endtask

   task automatic test_wb_write();
      wb_we = 1; wb_reg = 5; wb_data = 32'hDEADBEEF;
      tick();
      wb_we = 0; wb_reg = 0; wb_data = 0;
      checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL wb_we got %0h want 1", RegWrite); end
      checks++; if (WriteReg !== 5'd5) begin errors++; $display("FAIL wb_reg got %0d want 5", WriteReg); end
      checks++; if (WriteData !== 32'hDEADBEEF) begin errors++; $display("FAIL wb_data got %0h want deadbeef", WriteData); end
      tick();
      checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL wb_hold got %0h want 0", RegWrite); end
   endtask

   task automatic test_mc_single();
      mc_valid = 1; mc_reg = 7; mc_data = 32'h11;
      #1;
      checks++; if (mc_ready !== 1'b1) begin errors++; $display("FAIL mc_ready got %0h want 1", mc_ready); end
      tick();
      idle();
      checks++; if (pend_mask !== 32'h80) begin errors++; $display("FAIL mc_mask got %0h want 80", pend_mask); end
      checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL mc_count got %0d want 1", fifo_count); end
      checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL mc_early got %0h want 0", RegWrite); end
      tick();
      checks++; if (RegWrite !== 1'b1 || WriteReg !== 5'd7) begin errors++; $display("FAIL mc_issue got %0h/%0d want 1/7", RegWrite, WriteReg); end
      checks++; if (WriteData !== 32'h11) begin errors++; $display("FAIL mc_data got %0h want 11", WriteData); end
      checks++; if (pend_mask !== 32'd0) begin errors++; $display("FAIL mc_mask_clr got %0h want 0", pend_mask); end
      tick();
      checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL mc_hold got %0h want 0", RegWrite); end
   endtask

   task automatic test_full();
      wb_we = 1; wb_reg = 9; wb_data = 32'h99;
      for (int k = 1; k <= 4; k++) begin
         mc_valid = 1; mc_reg = 5'(k); mc_data = 32'h100 + 32'(k);
         tick();
         checks++; if (RegWrite !== 1'b1 || WriteReg !== 5'd9) begin errors++; $display("FAIL full_wb%0d got %0h/%0d want 1/9", k, RegWrite, WriteReg); end
      end
      checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_count got %0d want 4", fifo_count); end
      checks++; if (pend_mask !== 32'h1E) begin errors++; $display("FAIL full_mask got %0h want 1e", pend_mask); end
      mc_valid = 1; mc_reg = 5'd5; mc_data = 32'h105;
      #1;
      checks++; if (mc_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %0h want 0", mc_ready); end
      tick();
      checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_stall got %0d want 4", fifo_count); end
      checks++; if (WriteReg !== 5'd9) begin errors++; $display("FAIL full_wb5 got %0d want 9", WriteReg); end
      idle();
      for (int k = 1; k <= 4; k++) begin
         tick();
         checks++; if (RegWrite !== 1'b1 || WriteReg !== 5'(k)) begin errors++; $display("FAIL drain%0d got %0h/%0d want 1/%0d", k, RegWrite, WriteReg, k); end
         checks++; if (WriteData !== 32'h100 + 32'(k)) begin errors++; $display("FAIL drain_data%0d got %0h want %0h", k, WriteData, 32'h100 + 32'(k)); end
      end
      tick();
      checks++; if (RegWrite !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL drain_end got %0h/%0d want 0/0", RegWrite, fifo_count); end
   endtask

   task automatic test_zero_reg();
      wb_we = 1; wb_reg = 0; wb_data = 32'hBAD;
      tick();
      idle();
      checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL r0_wb got %0h want 0", RegWrite); end
      mc_valid = 1; mc_reg = 6; mc_data = 32'h66;
      tick();
      wb_we = 1; wb_reg = 0; wb_data = 32'hBAD;
      mc_valid = 0; mc_reg = 0; mc_data = 0;
      tick();
      idle();
      checks++; if (RegWrite !== 1'b1 || WriteReg !== 5'd6) begin errors++; $display("FAIL r0_drain got %0h/%0d want 1/6", RegWrite, WriteReg); end
      checks++; if (WriteData !== 32'h66) begin errors++; $display("FAIL r0_data got %0h want 66", WriteData); end
      mc_valid = 1; mc_reg = 0; mc_data = 32'h77;
      #1;
      checks++; if (mc_ready !== 1'b1) begin errors++; $display("FAIL r0_ready got %0h want 1", mc_ready); end
      tick();
      idle();
      checks++; if (fifo_count !== 3'd0 || pend_mask !== 32'd0) begin errors++; $display("FAIL r0_drop got %0d/%0h want 0/0", fifo_count, pend_mask); end
      tick();
      checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL r0_never got %0h want 0", RegWrite); end
   endtask

   task automatic test_back_to_back();
      mc_valid = 1; mc_reg = 1; mc_data = 32'hA1;
      tick();
      mc_reg = 2; mc_data = 32'hA2;
      tick();
      idle();
      checks++; if (RegWrite !== 1'b1 || WriteReg !== 5'd1) begin errors++; $display("FAIL b2b_1 got %0h/%0d want 1/1", RegWrite, WriteReg); end
      checks++; if (fifo_count !== 3'd1 || pend_mask !== 32'h4) begin errors++; $display("FAIL b2b_cnt got %0d/%0h want 1/4", fifo_count, pend_mask); end
      tick();
      checks++; if (WriteReg !== 5'd2 || WriteData !== 32'hA2) begin errors++; $display("FAIL b2b_2 got %0d/%0h want 2/a2", WriteReg, WriteData); end
      tick();
   endtask

   task automatic test_reset_mid();
      wb_we = 1; wb_reg = 9; wb_data = 32'h99;
      for (int k = 0; k < 3; k++) begin
         mc_valid = 1; mc_reg = 5'(10 + k); mc_data = 32'(k);
         tick();
      end
      mc_valid = 0;
      checks++; if (fifo_count !== 3'd3 || RegWrite !== 1'b1) begin errors++; $display("FAIL mid_pre got %0d/%0h want 3/1", fifo_count, RegWrite); end
      #2;
      rst = 0;
      #1;
      checks++; if (RegWrite !== 1'b0 || WriteReg !== 5'd0 || WriteData !== 32'd0) begin errors++; $display("FAIL mid_out got %0h/%0d/%0h want 0/0/0", RegWrite, WriteReg, WriteData); end
      checks++; if (mc_ready !== 1'b0) begin errors++; $display("FAIL mid_ready got %0h want 0", mc_ready); end
      idle();
      tick();
      rst = 1;
      tick();
      checks++; if (fifo_count !== 3'd0 || pend_mask !== 32'd0) begin errors++; $display("FAIL mid_post got %0d/%0h want 0/0", fifo_count, pend_mask); end
      checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL mid_we got %0h want 0", RegWrite); end
   endtask

`ifdef RWA_STARVE_GUARD_EN
   task automatic test_starve();
      mc_valid = 1; mc_reg = 3; mc_data = 32'h33;
      tick();
      idle();
      wb_we = 1; wb_reg = 9; wb_data = 32'h99;
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++; if (WriteReg !== 5'd9) begin errors++; $display("FAIL starve_wb%0d got %0d want 9", i, WriteReg); end
         if (i < 7) begin
            checks++; if (wb_stall !== 1'b0) begin errors++; $display("FAIL starve_early%0d got %0h want 0", i, wb_stall); end
         end
      end
      checks++; if (wb_stall !== 1'b1) begin errors++; $display("FAIL starve_pulse got %0h want 1", wb_stall); end
      tick();
      checks++; if (RegWrite !== 1'b1 || WriteReg !== 5'd3) begin errors++; $display("FAIL starve_issue got %0h/%0d want 1/3", RegWrite, WriteReg); end
      checks++; if (wb_stall !== 1'b0) begin errors++; $display("FAIL starve_end got %0h want 0", wb_stall); end
      idle();
      tick();
   endtask
`endif

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_wb_write();
      test_mc_single();
      test_full();
      test_zero_reg();
      test_back_to_back();
      test_reset_mid();
`ifdef RWA_STARVE_GUARD_EN
      test_starve();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
